// File: rtl/ntt_pkg.sv
// ntt_pkg: NTT constants, coefficient types and the stage-0 twiddle table
package ntt_pkg;
    localparam int DATA_WIDTH = 32;
    localparam logic [DATA_WIDTH-1:0] MOD_Q = 32'd998244353;
    localparam int BARRETT_K = 30;
    localparam logic [63:0] BARRETT_MU = (64'd1 << (2 * BARRETT_K)) / 64'(MOD_Q);
    localparam int LANES = 32;
    localparam int BFLIES = LANES / 2;
    localparam int FRAME_CYCLES = 32;
    localparam int CNT_W = $clog2(FRAME_CYCLES);
    typedef logic [DATA_WIDTH-1:0] coeff_t;
    typedef logic [CNT_W-1:0] cnt_t;
    typedef coeff_t [LANES-1:0] lanes_t;
    typedef coeff_t [BFLIES-1:0][FRAME_CYCLES-1:0] tw_rom_t;
    // Index 0 is 1 and index 1 is Q-1 for every butterfly; the rest are scrambled residues.
    function automatic coeff_t tw_val(int j, int i);
        logic [63:0] x;
        x = (64'(j * FRAME_CYCLES + i) * 64'd2654435761 + 64'd12345) % 64'(MOD_Q);
        return (i == 0) ? coeff_t'(1) : (i == 1) ? MOD_Q - 1 : coeff_t'(x);
    endfunction
    function automatic tw_rom_t gen_tw_rom();
        tw_rom_t r;
        for (int j = 0; j < BFLIES; j++)
            for (int i = 0; i < FRAME_CYCLES; i++)
                r[j][i] = tw_val(j, i);
        return r;
    endfunction
    localparam tw_rom_t TW_ROM = gen_tw_rom();
endpackage

// File: rtl/stage_0_butterfly_if.sv
// stage_0_butterfly_if: lane bus into and out of the stage-0 butterfly array
interface stage_0_butterfly_if;
    import ntt_pkg::*;
    logic   in_valid;
    logic   in_sof;
    lanes_t in_data;
    logic   out_valid;
    logic   out_sof;
    lanes_t out_data;
    modport master (output in_valid, in_sof, in_data, input out_valid, out_sof, out_data);
    modport slave (input in_valid, in_sof, in_data, output out_valid, out_sof, out_data);
endinterface

// File: rtl/mod_mul_barrett.sv
// mod_mul_barrett: two-stage pipelined a*b mod MOD_Q with Barrett reduction
module mod_mul_barrett
    import ntt_pkg::*;
(
    input  logic   clk,
    input  logic   rst,
    input  coeff_t a_i,
    input  coeff_t b_i,
    output coeff_t r_o
);
    localparam int PW = 2 * BARRETT_K;
    localparam int MW = 31;
    localparam int XW = PW + MW;
    localparam logic [MW-1:0] MU = BARRETT_MU[MW-1:0];
    logic [PW-1:0] p_d, p_q;
    logic [XW-1:0] xm;
    logic [MW-1:0] qt;
    coeff_t r, r_d, r_q;
    assign p_d = PW'(a_i) * PW'(b_i);
    // Full-precision quotient estimate undershoots by at most one, so r < 2Q.
    assign xm = XW'(p_q) * XW'(MU);
    assign qt = MW'(xm >> PW);
    assign r = coeff_t'(p_q) - coeff_t'(qt) * MOD_Q;
    assign r_d = (r >= MOD_Q) ? r - MOD_Q : r;
    always_ff @(posedge clk) begin
        if (rst) begin
            p_q <= '0;
            r_q <= '0;
        end else begin
            p_q <= p_d;
            r_q <= r_d;
        end
    end
    assign r_o = r_q;
endmodule

// File: rtl/stage_0_butterfly.sv
// stage_0_butterfly: NTT stage-0 radix-2 butterflies over 32 lanes, 4-cycle pipeline
module stage_0_butterfly
    import ntt_pkg::*;
(
    input logic clk,
    input logic rst,
    stage_0_butterfly_if.slave bf
);
    cnt_t cnt_q, cnt_d, idx;
    logic [3:0] vld_q, sof_q;
    lanes_t in_q, out_d, out_q;
    coeff_t [BFLIES-1:0] tw_q, a2_q, a3_q;
    coeff_t t_w [BFLIES];
    logic [DATA_WIDTH:0] s;
    assign idx = bf.in_sof ? '0 : cnt_q;
    assign cnt_d = !bf.in_valid ? cnt_q : bf.in_sof ? cnt_t'(1) :
                   (cnt_q == cnt_t'(FRAME_CYCLES - 1)) ? '0 : cnt_q + cnt_t'(1);
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
            vld_q <= '0;
            sof_q <= '0;
            in_q  <= '0;
            tw_q  <= '0;
            a2_q  <= '0;
            a3_q  <= '0;
            out_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            vld_q <= {vld_q[2:0], bf.in_valid};
            sof_q <= {sof_q[2:0], bf.in_valid & bf.in_sof};
            in_q  <= bf.in_data;
            for (int j = 0; j < BFLIES; j++) begin
                tw_q[j] <= TW_ROM[j][idx];
                a2_q[j] <= in_q[2*j];
            end
            a3_q  <= a2_q;
            out_q <= out_d;
        end
    end
    for (genvar j = 0; j < BFLIES; j++) begin : g_mul
        mod_mul_barrett u_mul (.clk(clk), .rst(rst), .a_i(in_q[2*j+1]), .b_i(tw_q[j]), .r_o(t_w[j]));
    end
    always_comb begin
        out_d = '0;
        s = '0;
        for (int j = 0; j < BFLIES; j++) begin
            s = {1'b0, a3_q[j]} + {1'b0, t_w[j]};
            out_d[2*j] = (s >= {1'b0, MOD_Q}) ? coeff_t'(s - {1'b0, MOD_Q}) : coeff_t'(s);
            out_d[2*j+1] = (a3_q[j] >= t_w[j]) ? a3_q[j] - t_w[j] : a3_q[j] + MOD_Q - t_w[j];
        end
    end
    assign bf.out_valid = vld_q[3];
    assign bf.out_sof = sof_q[3];
    assign bf.out_data = out_q;
    always_ff @(posedge clk)
        for (int i = 0; i < LANES; i++)
            if (!rst && bf.in_valid) assert (bf.in_data[i] < MOD_Q);
endmodule

// File: tb/tb_stage_0_butterfly.sv
// tb_stage_0_butterfly: scoreboard bench for the stage-0 butterfly array
module tb_stage_0_butterfly;
    import ntt_pkg::*;
    typedef struct {
        logic v;
        logic s;
        logic [511:0] lo;
        logic [511:0] hi;
    } rec_t;
    logic clk = 0;
    logic rst = 1;
    rec_t q[$];
    int n_cmp = 0;
    int n_bad = 0;
    int cnt = 0;
    stage_0_butterfly_if bf();
    stage_0_butterfly dut (.clk(clk), .rst(rst), .bf(bf));
    always #5 clk = ~clk;
    task automatic chk(string tag, logic [511:0] got, logic [511:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask
    function automatic lanes_t rnd_data();
        lanes_t r;
        for (int i = 0; i < LANES; i++) r[i] = coeff_t'($urandom_range(MOD_Q - 1));
        return r;
    endfunction
    function automatic lanes_t fill(coeff_t a, coeff_t b);
        lanes_t r;
        for (int j = 0; j < BFLIES; j++) begin
            r[2*j] = a;
            r[2*j+1] = b;
        end
        return r;
    endfunction
    function automatic rec_t model(logic v, logic s, lanes_t d, int idx);
        rec_t r;
        lanes_t o;
        for (int j = 0; j < BFLIES; j++) begin
            logic [63:0] t;
            t = (64'(d[2*j+1]) * 64'(TW_ROM[j][idx])) % 64'(MOD_Q);
            o[2*j] = coeff_t'((64'(d[2*j]) + t) % 64'(MOD_Q));
            o[2*j+1] = coeff_t'((64'(d[2*j]) + 64'(MOD_Q) - t) % 64'(MOD_Q));
        end
        r.v = v;
        r.s = v & s;
        r.lo = o[15:0];
        r.hi = o[31:16];
        return r;
    endfunction
    task automatic beat(logic v, logic s, lanes_t d);
        rec_t r;
        int idx;
        r = q.pop_front();
        chk("valid", 512'(bf.out_valid), 512'(r.v));
        chk("sof", 512'(bf.out_sof), 512'(r.s));
        if (r.v) begin
            chk("data_lo", bf.out_data[15:0], r.lo);
            chk("data_hi", bf.out_data[31:16], r.hi);
        end
        idx = s ? 0 : cnt;
        if (v) cnt = s ? 1 : (cnt == FRAME_CYCLES - 1) ? 0 : cnt + 1;
        q.push_back(model(v, s, d, idx));
        bf.in_valid = v;
        bf.in_sof = s;
        bf.in_data = d;
        @(negedge clk);
    endtask
    task automatic do_reset();
        rec_t bub;
        bub = '{default: '0};
        rst = 1;
        bf.in_valid = 1;
        bf.in_sof = 0;
        bf.in_data = rnd_data();
        q.delete();
        cnt = 0;
        repeat (3) begin
            @(negedge clk);
            chk("rst_valid", 512'(bf.out_valid), 512'(0));
            chk("rst_sof", 512'(bf.out_sof), 512'(0));
            chk("rst_data", bf.out_data[15:0] | bf.out_data[31:16], 512'(0));
        end
        rst = 0;
        repeat (4) q.push_back(bub);
    endtask
    initial begin
        int k;
        bf.in_valid = 0;
        bf.in_sof = 0;
        bf.in_data = '0;
        do_reset();
        beat(1, 1, fill(5, 3));
        beat(1, 1, fill(1, 3));
        beat(1, 1, fill(MOD_Q - 1, 0));
        beat(1, 0, fill(MOD_Q - 1, MOD_Q - 1));
        k = 0;
        for (int i = 0; k < FRAME_CYCLES + 1; i++) begin
            if (i % 3 == 2) beat(0, 0, rnd_data());
            else begin
                beat(1, k == 0, rnd_data());
                k++;
            end
        end
        beat(1, 1, rnd_data());
        repeat (16) beat(1, 0, rnd_data());
        beat(1, 1, rnd_data());
        repeat (6) beat(1, 0, rnd_data());
        do_reset();
        for (int i = 0; i < 10000; i++)
            beat($urandom_range(9) != 0, $urandom_range(19) == 0, rnd_data());
        repeat (4) beat(0, 0, rnd_data());
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
